// File: rtl/wam_pkg.sv
// Shared types and helpers for the whack-a-mole hit judge.
//   N_HOLES     : number of holes/buttons (fixes the width of hole_vec_t)
//   SCORE_W_DEF : default width of the score and miss counters
//   CNT_W       : width able to hold a count of 0..N_HOLES set bits
//   hole_vec_t  : one bit per hole
//   hit_state_t : per-hole judge state
//   popcount    : number of set bits in a hole_vec_t
package wam_pkg;

    localparam int unsigned N_HOLES     = 8;
    localparam int unsigned SCORE_W_DEF = 8;
    localparam int unsigned CNT_W       = $clog2(N_HOLES + 1);

    typedef logic [N_HOLES-1:0] hole_vec_t;

    typedef enum logic {
        HS_IDLE     = 1'b0,
        HS_WAIT_ACK = 1'b1
    } hit_state_t;

    // Count of asserted holes in a vector.
    function automatic logic [CNT_W-1:0] popcount(input hole_vec_t v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < int'(N_HOLES); i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/wam_debounce.sv
// One hole button: 2-flop synchronizer, level debouncer and rising-edge press pulse.
//   clk        : system clock
//   clr        : asynchronous active-high reset
//   i_btn      : raw asynchronous button level
//   o_press_c  : one-cycle pulse when the debounced level rises (decoded from flops only)
// The debounced level flips only after DB_CYCLES consecutive synchronized samples that
// differ from it; any sample agreeing with the current level restarts the count.
module wam_debounce #(
    parameter int unsigned DB_CYCLES = 50000
) (
    input  logic clk,
    input  logic clr,
    input  logic i_btn,
    output logic o_press_c
);

    localparam int unsigned DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    logic [1:0]      r_sync;
    logic            r_db;
    logic            r_db_q;
    logic [DB_W-1:0] r_cnt;

    // Synchronizer, debounce counter and delayed level for edge detection.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_sync <= 2'b00;
            r_db   <= 1'b0;
            r_db_q <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_sync <= {r_sync[0], i_btn};
            r_db_q <= r_db;
            if (r_sync[1] == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == DB_LAST) begin
                r_db  <= r_sync[1];
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + DB_W'(1);
            end
        end
    end

    assign o_press_c = r_db & ~r_db_q;

endmodule

// File: rtl/wam_hit.sv
// Player-side judge for the mole game. Debounces the hole buttons, raises a per-hole hit
// request for every press on a live mole and holds it until the generator clears that mole
// (acknowledge) or a timeout expires. Counts accepted hits (score) and presses on empty
// holes (miss), both saturating.
//   clk     : system clock
//   clr     : asynchronous active-high reset
//   btn     : raw asynchronous hole buttons
//   holes   : live moles from the generator, also the acknowledge for hit
//   hit     : registered hit request per hole
//   score   : accepted hits, saturating
//   miss    : presses on empty holes, saturating
//   ack_err : sticky, set when a hit request timed out
// Build option: define WAM_HIT_PENALTY_EN to make each miss also take one point off the
// score (net per-cycle change = hits - misses, clamped to the counter range).
module wam_hit
    import wam_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 50000,
    parameter int unsigned ACK_TO    = 4194304,
    parameter int unsigned SCORE_W   = SCORE_W_DEF
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [N_HOLES-1:0] btn,
    input  logic [N_HOLES-1:0] holes,
    output logic [N_HOLES-1:0] hit,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] miss,
    output logic               ack_err
);

    localparam int unsigned TO_W  = (ACK_TO > 1) ? $clog2(ACK_TO) : 1;
    localparam int unsigned SUM_W = SCORE_W + CNT_W + 1;
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(ACK_TO - 1);
    localparam logic [SUM_W-1:0] SAT     = SUM_W'({SCORE_W{1'b1}});

    hole_vec_t       w_press;
    hit_state_t      r_state   [N_HOLES];
    hit_state_t      w_state_nx[N_HOLES];
    logic [TO_W-1:0] r_cnt     [N_HOLES];
    logic [TO_W-1:0] w_cnt_nx  [N_HOLES];
    hole_vec_t       r_hit;
    hole_vec_t       w_hit_nx;
    hole_vec_t       w_acc;
    hole_vec_t       w_mis;
    logic            r_ack_err;
    logic            w_err_nx;
    logic [SCORE_W-1:0] r_score;
    logic [SCORE_W-1:0] r_miss;
    logic [SCORE_W-1:0] w_score_nx;
    logic [SCORE_W-1:0] w_miss_nx;
    logic [CNT_W-1:0]   w_hits;
    logic [CNT_W-1:0]   w_misses;
    logic [SUM_W-1:0]   w_ssum;
    logic [SUM_W-1:0]   w_msum;

    // Per-hole input conditioning.
    for (genvar g = 0; g < int'(N_HOLES); g++) begin : g_db
        wam_debounce #(
            .DB_CYCLES (DB_CYCLES)
        ) u_db (
            .clk       (clk),
            .clr       (clr),
            .i_btn     (btn[g]),
            .o_press_c (w_press[g])
        );
    end

    // State, timeout counters and all outputs are registered here.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state   <= '{default: HS_IDLE};
            r_cnt     <= '{default: '0};
            r_hit     <= '0;
            r_ack_err <= 1'b0;
            r_score   <= '0;
            r_miss    <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_hit     <= w_hit_nx;
            r_ack_err <= w_err_nx;
            r_score   <= w_score_nx;
            r_miss    <= w_miss_nx;
        end
    end

    // Per-hole judge FSMs: classify presses, hold hit until ack or timeout.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_hit_nx   = r_hit;
        w_acc      = '0;
        w_mis      = '0;
        w_err_nx   = r_ack_err;
        for (int i = 0; i < int'(N_HOLES); i++) begin
            case (r_state[i])
                HS_IDLE: begin
                    w_hit_nx[i] = 1'b0;
                    if (w_press[i]) begin
                        // holes is sampled in the press cycle; a mole leaving now is a miss
                        if (holes[i]) begin
                            w_state_nx[i] = HS_WAIT_ACK;
                            w_hit_nx[i]   = 1'b1;
                            w_cnt_nx[i]   = '0;
                            w_acc[i]      = 1'b1;
                        end else begin
                            w_mis[i] = 1'b1;
                        end
                    end
                end
                HS_WAIT_ACK: begin
                    // further presses are ignored; ack takes priority over timeout
                    w_hit_nx[i] = 1'b1;
                    if (!holes[i]) begin
                        w_state_nx[i] = HS_IDLE;
                        w_hit_nx[i]   = 1'b0;
                    end else if (r_cnt[i] == TO_LAST) begin
                        w_state_nx[i] = HS_IDLE;
                        w_hit_nx[i]   = 1'b0;
                        w_err_nx      = 1'b1;
                    end else begin
                        w_cnt_nx[i] = r_cnt[i] + TO_W'(1);
                    end
                end
            endcase
        end
    end

    // Score and miss update: all holes of one cycle applied together, saturating.
    always_comb begin
        w_hits   = popcount(w_acc);
        w_misses = popcount(w_mis);
        w_msum   = SUM_W'(r_miss) + SUM_W'(w_misses);
`ifdef WAM_HIT_PENALTY_EN
        // wraps below zero into the top bit, which cannot be reached by a positive sum
        w_ssum   = SUM_W'(r_score) + SUM_W'(w_hits) - SUM_W'(w_misses);
`else
        w_ssum   = SUM_W'(r_score) + SUM_W'(w_hits);
`endif
        w_miss_nx  = (w_msum > SAT) ? {SCORE_W{1'b1}} : SCORE_W'(w_msum);
        w_score_nx = SCORE_W'(w_ssum);
        if (w_ssum[SUM_W-1]) begin
            w_score_nx = '0;
        end else if (w_ssum > SAT) begin
            w_score_nx = {SCORE_W{1'b1}};
        end
    end

    assign hit     = r_hit;
    assign score   = r_score;
    assign miss    = r_miss;
    assign ack_err = r_ack_err;

endmodule

// File: tb/tb_wam_hit.sv
// Directed self-checking bench for wam_hit (DB_CYCLES=4, ACK_TO=32, SCORE_W=4).
module tb_wam_hit;

    localparam int unsigned SW = 4;

    logic          clk = 1'b0;
    logic          clr;
    logic [7:0]    btn;
    logic [7:0]    holes;
    logic [7:0]    hit;
    logic [SW-1:0] score;
    logic [SW-1:0] miss;
    logic          ack_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] btn;
        logic [7:0] holes;
        logic [7:0] exp_hit;
        int         exp_score;
        int         exp_miss;
    } vec_t;

    vec_t tbl[11];

    wam_hit #(
        .DB_CYCLES (4),
        .ACK_TO    (32),
        .SCORE_W   (SW)
    ) dut (
        .clk     (clk),
        .clr     (clr),
        .btn     (btn),
        .holes   (holes),
        .hit     (hit),
        .score   (score),
        .miss    (miss),
        .ack_err (ack_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string name, input logic [7:0] eh, input int es,
                           input int em, input logic ee);
        chk({name, " hit"}, 32'(hit), 32'(eh));
        chk({name, " score"}, 32'(score), 32'(es));
        chk({name, " miss"}, 32'(miss), 32'(em));
        chk({name, " ack_err"}, 32'(ack_err), 32'(ee));
    endtask

    task automatic do_reset();
        btn   = '0;
        holes = '0;
        clr   = 1'b1;
        tick(2);
        clr = 1'b0;
        tick(1);
    endtask

    // Poll until hit[idx] rises, bounded; the final compare fails if the bound expired.
    task automatic wait_hit(input string name, input int idx, input int budget);
        int k;
        k = 0;
        while (k < budget && hit[idx] !== 1'b1) begin
            tick(1);
            k++;
        end
        chk({name, " hit rise"}, 32'(hit[idx]), 32'd1);
    endtask

    function automatic int sat(input int v);
        if (v > 15) return 15;
        if (v < 0) return 0;
        return v;
    endfunction

    initial begin
        int rises;
        int held;
        logic prev;

        // Mixed-press table: each row is held 12 cycles before checking.
        tbl[0]  = '{8'h00, 8'h0F, 8'h00, 0, 0};
        tbl[1]  = '{8'hF0, 8'h0F, 8'h00, 0, 4};
        tbl[2]  = '{8'h00, 8'h0F, 8'h00, 0, 4};
        tbl[3]  = '{8'h03, 8'h0F, 8'h03, 2, 4};
        tbl[4]  = '{8'h02, 8'h0F, 8'h03, 2, 4};
        tbl[5]  = '{8'h03, 8'h0F, 8'h03, 2, 4};
        tbl[6]  = '{8'h00, 8'h0C, 8'h00, 2, 4};
        tbl[7]  = '{8'h04, 8'h0C, 8'h04, 3, 4};
        tbl[8]  = '{8'h00, 8'h00, 8'h00, 3, 4};
`ifdef WAM_HIT_PENALTY_EN
        tbl[9]  = '{8'h88, 8'h08, 8'h08, 3, 5};
        tbl[10] = '{8'h00, 8'h00, 8'h00, 3, 5};
`else
        tbl[9]  = '{8'h88, 8'h08, 8'h08, 4, 5};
        tbl[10] = '{8'h00, 8'h00, 8'h00, 4, 5};
`endif

        // Reset held while buttons and moles toggle.
        clr   = 1'b1;
        btn   = '0;
        holes = '0;
        tick(1);
        for (int c = 0; c < 12; c++) begin
            btn   = 8'($urandom);
            holes = 8'($urandom);
            tick(1);
            chk_all($sformatf("reset c%0d", c), 8'h00, 0, 0, 1'b0);
        end
        btn   = '0;
        holes = '0;
        clr   = 1'b0;
        tick(1);
        chk_all("reset release", 8'h00, 0, 0, 1'b0);

        // Bounce on btn[2], then a clean hold: exactly one hit.
        do_reset();
        holes = 8'h04;
        rises = 0;
        prev  = 1'b0;
        for (int c = 0; c < 35; c++) begin
            if (c < 20) begin
                if (c % 2 == 0) btn[2] = ~btn[2];
            end else begin
                btn[2] = 1'b1;
            end
            tick(1);
            if (hit[2] && !prev) rises++;
            prev = hit[2];
            if (c == 19) chk("bounce no hit", 32'(hit), 32'h0);
        end
        chk("bounce rises", 32'(rises), 32'd1);
        chk_all("bounce held", 8'h04, 1, 0, 1'b0);
        holes = 8'h00;
        tick(1);
        chk("bounce ack", 32'(hit), 32'h0);
        btn = '0;
        tick(10);
        chk_all("bounce release", 8'h00, 1, 0, 1'b0);

        // Handshake on hole 5.
        do_reset();
        holes = 8'h20;
        btn   = 8'h20;
        wait_hit("hs", 5, 20);
        held = 0;
        for (int c = 0; c < 10; c++) begin
            tick(1);
            if (hit[5]) held++;
        end
        chk("hs held", 32'(held), 32'd10);
        holes = 8'h00;
        tick(1);
        chk_all("hs ack", 8'h00, 1, 0, 1'b0);

        // Asynchronous reset while waiting for ack.
        btn = '0;
        tick(10);
        holes = 8'h20;
        btn   = 8'h20;
        wait_hit("hs2", 5, 20);
        chk("hs2 score", 32'(score), 32'd2);
        clr = 1'b1;
        #1;
        chk("async clr hit", 32'(hit), 32'h0);
        chk("async clr score", 32'(score), 32'd0);
        btn   = '0;
        holes = '0;
        tick(1);
        clr = 1'b0;
        tick(1);

        // Timeout on hole 1.
        do_reset();
        holes = 8'h02;
        btn   = 8'h02;
        wait_hit("to", 1, 20);
        held = 0;
        for (int c = 0; c < 31; c++) begin
            tick(1);
            if (hit[1]) held++;
        end
        chk("to held", 32'(held), 32'd31);
        chk("to err before", 32'(ack_err), 32'd0);
        tick(1);
        chk_all("to expired", 8'h00, 1, 0, 1'b1);
        holes = 8'h00;
        btn   = 8'h00;
        tick(10);
        chk("to sticky", 32'(ack_err), 32'd1);

        // Ack arriving on the timeout cycle wins.
        do_reset();
        holes = 8'h02;
        btn   = 8'h02;
        wait_hit("race", 1, 20);
        tick(31);
        chk("race still high", 32'(hit[1]), 32'd1);
        holes = 8'h00;
        tick(1);
        chk_all("race ack", 8'h00, 1, 0, 1'b0);

        // Mole drops exactly on the press cycle -> miss; one cycle later -> hit.
        do_reset();
        holes = 8'h08;
        btn   = 8'h08;
        tick(6);
        holes = 8'h00;
        tick(1);
        chk_all("drop same cycle", 8'h00, 0, 1, 1'b0);
        btn = 8'h00;
        tick(10);
        holes = 8'h08;
        btn   = 8'h08;
        tick(7);
        chk_all("drop next cycle", 8'h08, 1, 1, 1'b0);
        holes = 8'h00;
        tick(1);
        chk("drop next ack", 32'(hit), 32'h0);
        btn = 8'h00;
        tick(10);

        // Mixed multi-hole table.
        do_reset();
        for (int i = 0; i < 11; i++) begin
            btn   = tbl[i].btn;
            holes = tbl[i].holes;
            tick(12);
            chk_all($sformatf("tbl%0d", i), tbl[i].exp_hit, tbl[i].exp_score,
                    tbl[i].exp_miss, 1'b0);
        end

        // Saturation: 20 accepted hits then 20 misses.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            holes[i % 8] = 1'b1;
            btn[i % 8]   = 1'b1;
            wait_hit($sformatf("sat%0d", i), i % 8, 20);
            holes = 8'h00;
            tick(1);
            btn = 8'h00;
            tick(10);
            chk($sformatf("sat score %0d", i), 32'(score), 32'(sat(i + 1)));
        end
        for (int i = 0; i < 20; i++) begin
            btn[i % 8] = 1'b1;
            tick(10);
            btn = 8'h00;
            tick(10);
            chk($sformatf("sat miss %0d", i), 32'(miss), 32'(sat(i + 1)));
`ifdef WAM_HIT_PENALTY_EN
            chk($sformatf("sat pen score %0d", i), 32'(score), 32'(sat(15 - (i + 1))));
`else
            chk($sformatf("sat keep score %0d", i), 32'(score), 32'd15);
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
